// File: rtl/gray_seq_ctrl.sv
// Run controller for a W-bit Gray-code counter: one-shot or continuous runs with step/wrap/done strobes.
// Optional down-counting (DIR port) is enabled by defining GRAY_DOWN_EN.
module gray_seq_ctrl #(
    parameter int W = 3
) (
    input  logic         C,
    input  logic         R,
    input  logic         START,
    input  logic         STOP,
    input  logic         HOLD,
    input  logic         MODE,
    input  logic [W-1:0] LEN,
`ifdef GRAY_DOWN_EN
    input  logic         DIR,
`endif
    output logic [W-1:0] OUT,
    output logic         BUSY,
    output logic         STEP,
    output logic         WRAP,
    output logic         DONE
);

    typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

    state_t         state;
    logic [W-1:0]   idx;
    logic [W-1:0]   len_q;
    logic           mode_q;
    logic           dir_q;
    logic           start_dir;
    logic [W-1:0]   term_idx;
    logic [W-1:0]   next_idx;
    logic [W-1:0]   reload_idx;

    function automatic logic [W-1:0] to_gray(input logic [W-1:0] b);
        return b ^ (b >> 1);
    endfunction

`ifdef GRAY_DOWN_EN
    assign start_dir = DIR;
`else
    assign start_dir = 1'b0;
`endif

    // Up runs end at len_q and restart at 0; down runs end at 0 and restart at len_q.
    assign term_idx   = dir_q ? '0 : len_q;
    assign reload_idx = dir_q ? len_q : '0;
    assign next_idx   = dir_q ? (idx - 1'b1) : (idx + 1'b1);

    assign OUT  = to_gray(idx);
    assign BUSY = (state == RUN);

    always_ff @(posedge C) begin
        if (R) begin
            state  <= IDLE;
            idx    <= '0;
            len_q  <= '0;
            mode_q <= 1'b0;
            dir_q  <= 1'b0;
            STEP   <= 1'b0;
            WRAP   <= 1'b0;
            DONE   <= 1'b0;
        end else begin
            STEP <= 1'b0;
            WRAP <= 1'b0;
            DONE <= 1'b0;
            case (state)
                IDLE: begin
                    if (START && !STOP) begin
                        len_q  <= LEN;
                        mode_q <= MODE;
                        dir_q  <= start_dir;
                        idx    <= start_dir ? LEN : '0;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (STOP) begin
                        idx   <= '0;
                        state <= IDLE;
                    end else if (!HOLD) begin
                        if (idx == term_idx) begin
                            if (!mode_q) begin
                                // DONE is registered on entry so it is high exactly while in FIN.
                                state <= FIN;
                                DONE  <= 1'b1;
                            end else begin
                                idx  <= reload_idx;
                                STEP <= 1'b1;
                                WRAP <= 1'b1;
                            end
                        end else begin
                            idx  <= next_idx;
                            STEP <= 1'b1;
                        end
                    end
                end
                FIN: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gray_seq_ctrl.sv
// Directed self-checking bench for gray_seq_ctrl (W=3); the down-count scenario runs when GRAY_DOWN_EN is defined.
module tb_gray_seq_ctrl;

    logic       C = 1'b0;
    logic       R = 1'b1;
    logic       START = 1'b0;
    logic       STOP = 1'b0;
    logic       HOLD = 1'b0;
    logic       MODE = 1'b0;
    logic [2:0] LEN = 3'd0;
`ifdef GRAY_DOWN_EN
    logic       DIR = 1'b0;
`endif
    logic [2:0] OUT;
    logic       BUSY, STEP, WRAP, DONE;

    int checks = 0;
    int failures = 0;

    logic [2:0] gray_tab [8] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100};

    gray_seq_ctrl #(.W(3)) dut (
        .C(C), .R(R), .START(START), .STOP(STOP), .HOLD(HOLD), .MODE(MODE), .LEN(LEN),
`ifdef GRAY_DOWN_EN
        .DIR(DIR),
`endif
        .OUT(OUT), .BUSY(BUSY), .STEP(STEP), .WRAP(WRAP), .DONE(DONE)
    );

    always #5 C = ~C;

    task automatic tick();
        @(posedge C);
        #1;
    endtask

    task automatic test_reset();
        R = 1'b1;
        for (int i = 0; i < 2; i++) begin
            START = 1'($urandom); STOP = 1'($urandom); HOLD = 1'($urandom);
            MODE = 1'($urandom); LEN = 3'($urandom);
            tick();
        end
        checks++;
        if ({OUT, BUSY, STEP, WRAP, DONE} !== 7'b0) begin
            failures++;
            $display("FAIL reset: got OUT=%b BUSY=%b STEP=%b WRAP=%b DONE=%b, want all 0", OUT, BUSY, STEP, WRAP, DONE);
        end
        R = 1'b0; START = 1'b0; STOP = 1'b0; HOLD = 1'b0; MODE = 1'b0; LEN = 3'd0;
        tick();
    endtask

    task automatic test_oneshot();
        logic [2:0] exp_out [6] = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111};
        int steps = 0;
        START = 1'b1; MODE = 1'b0; LEN = 3'd5;
        tick();
        START = 1'b0; LEN = 3'd0;
        checks++;
        if (BUSY !== 1'b1 || OUT !== 3'b000 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL oneshot_start: got BUSY=%b OUT=%b STEP=%b, want 1 000 0", BUSY, OUT, STEP);
        end
        for (int i = 1; i <= 5; i++) begin
            tick();
            steps += int'(STEP);
            checks++;
            if (OUT !== exp_out[i] || STEP !== 1'b1 || DONE !== 1'b0 || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL oneshot_step%0d: got OUT=%b STEP=%b DONE=%b BUSY=%b, want %b 1 0 1", i, OUT, STEP, DONE, BUSY, exp_out[i]);
            end
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || STEP !== 1'b0 || OUT !== 3'b111 || steps != 5) begin
            failures++;
            $display("FAIL oneshot_done: got DONE=%b BUSY=%b STEP=%b OUT=%b steps=%0d, want 1 0 0 111 5", DONE, BUSY, STEP, OUT, steps);
        end
        tick();
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0 || OUT !== 3'b111) begin
            failures++;
            $display("FAIL oneshot_idle: got DONE=%b BUSY=%b OUT=%b, want 0 0 111", DONE, BUSY, OUT);
        end
    endtask

    task automatic test_continuous();
        int exp_idx = 0;
        int wraps = 0;
        logic [2:0] prev;
        START = 1'b1; MODE = 1'b1; LEN = 3'd7;
        tick();
        START = 1'b0; MODE = 1'b0;
        prev = OUT;
        for (int c = 0; c < 20; c++) begin
            logic exp_wrap;
            exp_wrap = (exp_idx == 7);
            exp_idx = (exp_idx + 1) % 8;
            tick();
            wraps += int'(WRAP);
            checks++;
            if (OUT !== gray_tab[exp_idx] || STEP !== 1'b1 || WRAP !== exp_wrap || $countones(OUT ^ prev) != 1) begin
                failures++;
                $display("FAIL cont_cycle%0d: got OUT=%b STEP=%b WRAP=%b prev=%b, want %b 1 %b single-bit", c, OUT, STEP, WRAP, prev, gray_tab[exp_idx], exp_wrap);
            end
            prev = OUT;
        end
        checks++;
        if (wraps != 2) begin
            failures++;
            $display("FAIL cont_wrapcount: got %0d, want 2", wraps);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || OUT !== 3'b000 || STEP !== 1'b0 || WRAP !== 1'b0 || DONE !== 1'b0) begin
            failures++;
            $display("FAIL cont_stop: got BUSY=%b OUT=%b STEP=%b WRAP=%b DONE=%b, want 0 000 0 0 0", BUSY, OUT, STEP, WRAP, DONE);
        end
    endtask

    task automatic test_hold_stop();
        int dones = 0;
        START = 1'b1; MODE = 1'b0; LEN = 3'd7;
        tick();
        START = 1'b0;
        tick();
        tick();
        checks++;
        if (OUT !== 3'b011) begin
            failures++;
            $display("FAIL hold_pre: got OUT=%b, want 011", OUT);
        end
        HOLD = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(DONE);
            checks++;
            if (OUT !== 3'b011 || STEP !== 1'b0 || WRAP !== 1'b0 || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL hold_cycle%0d: got OUT=%b STEP=%b WRAP=%b BUSY=%b, want 011 0 0 1", i, OUT, STEP, WRAP, BUSY);
            end
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0; HOLD = 1'b0;
        dones += int'(DONE);
        checks++;
        if (OUT !== 3'b000 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL hold_stop: got OUT=%b BUSY=%b, want 000 0", OUT, BUSY);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            dones += int'(DONE);
        end
        checks++;
        if (dones != 0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL hold_nodone: got done pulses=%0d BUSY=%b, want 0 0", dones, BUSY);
        end
    endtask

    task automatic test_ignored_start();
        START = 1'b1; STOP = 1'b1; LEN = 3'd3;
        tick();
        START = 1'b0; STOP = 1'b0;
        checks++;
        if (BUSY !== 1'b0 || OUT !== 3'b000) begin
            failures++;
            $display("FAIL start_stop_same: got BUSY=%b OUT=%b, want 0 000", BUSY, OUT);
        end
        START = 1'b1; MODE = 1'b0; LEN = 3'd2;
        tick();
        LEN = 3'd7; MODE = 1'b1;
        tick();
        START = 1'b0;
        tick();
        checks++;
        if (OUT !== 3'b011 || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL midrun_start: got OUT=%b BUSY=%b, want 011 1", OUT, BUSY);
        end
        START = 1'b1;
        tick();
        checks++;
        if (DONE !== 1'b1 || BUSY !== 1'b0 || OUT !== 3'b011) begin
            failures++;
            $display("FAIL midrun_lenq: got DONE=%b BUSY=%b OUT=%b, want 1 0 011", DONE, BUSY, OUT);
        end
        tick();
        START = 1'b0; MODE = 1'b0; LEN = 3'd0;
        checks++;
        if (BUSY !== 1'b0 || DONE !== 1'b0 || OUT !== 3'b011) begin
            failures++;
            $display("FAIL fin_start: got BUSY=%b DONE=%b OUT=%b, want 0 0 011", BUSY, DONE, OUT);
        end
        tick();
    endtask

    task automatic test_len_zero();
        START = 1'b1; MODE = 1'b0; LEN = 3'd0;
        tick();
        START = 1'b0;
        checks++;
        if (BUSY !== 1'b1 || OUT !== 3'b000) begin
            failures++;
            $display("FAIL len0_os_run: got BUSY=%b OUT=%b, want 1 000", BUSY, OUT);
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || STEP !== 1'b0 || BUSY !== 1'b0 || OUT !== 3'b000) begin
            failures++;
            $display("FAIL len0_os_fin: got DONE=%b STEP=%b BUSY=%b OUT=%b, want 1 0 0 000", DONE, STEP, BUSY, OUT);
        end
        tick();
        START = 1'b1; MODE = 1'b1;
        tick();
        START = 1'b0; MODE = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (WRAP !== 1'b1 || STEP !== 1'b1 || OUT !== 3'b000 || BUSY !== 1'b1) begin
                failures++;
                $display("FAIL len0_cont%0d: got WRAP=%b STEP=%b OUT=%b BUSY=%b, want 1 1 000 1", i, WRAP, STEP, OUT, BUSY);
            end
        end
        HOLD = 1'b1;
        tick();
        HOLD = 1'b0;
        checks++;
        if (WRAP !== 1'b0 || STEP !== 1'b0) begin
            failures++;
            $display("FAIL len0_hold: got WRAP=%b STEP=%b, want 0 0", WRAP, STEP);
        end
        STOP = 1'b1;
        tick();
        STOP = 1'b0;
        tick();
    endtask

`ifdef GRAY_DOWN_EN
    task automatic test_down();
        logic [2:0] exp_out [5] = '{3'b110, 3'b010, 3'b011, 3'b001, 3'b000};
        DIR = 1'b1; START = 1'b1; MODE = 1'b0; LEN = 3'd4;
        tick();
        DIR = 1'b0; START = 1'b0; LEN = 3'd0;
        checks++;
        if (OUT !== exp_out[0] || BUSY !== 1'b1) begin
            failures++;
            $display("FAIL down_start: got OUT=%b BUSY=%b, want %b 1", OUT, BUSY, exp_out[0]);
        end
        for (int i = 1; i < 5; i++) begin
            tick();
            checks++;
            if (OUT !== exp_out[i] || STEP !== 1'b1) begin
                failures++;
                $display("FAIL down_step%0d: got OUT=%b STEP=%b, want %b 1", i, OUT, STEP, exp_out[i]);
            end
        end
        tick();
        checks++;
        if (DONE !== 1'b1 || OUT !== 3'b000) begin
            failures++;
            $display("FAIL down_done: got DONE=%b OUT=%b, want 1 000", DONE, OUT);
        end
        tick();
        checks++;
        if (DONE !== 1'b0 || BUSY !== 1'b0) begin
            failures++;
            $display("FAIL down_idle: got DONE=%b BUSY=%b, want 0 0", DONE, BUSY);
        end
    endtask
`endif

    task automatic test_reset_midrun();
        START = 1'b1; MODE = 1'b1; LEN = 3'd6;
        tick();
        START = 1'b0;
        tick();
        tick();
        R = 1'b1; START = 1'($urandom); MODE = 1'($urandom); LEN = 3'($urandom);
        tick();
        checks++;
        if ({OUT, BUSY, STEP, WRAP, DONE} !== 7'b0) begin
            failures++;
            $display("FAIL reset_midrun: got OUT=%b BUSY=%b STEP=%b WRAP=%b DONE=%b, want all 0", OUT, BUSY, STEP, WRAP, DONE);
        end
        R = 1'b0; START = 1'b0; MODE = 1'b0; LEN = 3'd0;
        tick();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_continuous();
        test_hold_stop();
        test_ignored_start();
        test_len_zero();
`ifdef GRAY_DOWN_EN
        test_down();
`endif
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
